kanagawa_sim_mailbox_to_ready_valid: RTL and testbench
======================================================

# kanagawa_sim_mailbox_to_ready_valid

Simulation-only source stage that drives a DUT input port from a typed mailbox. The testbench calls `put()` / `try_put()`. The block pops items and presents them on a ready/valid interface, with an optional pseudo-random idle gap between transfers. It sits upstream of the DUT and is the mirror of the mailbox-capturing sink. It can drive valid-only ports by tying `ready_in` high.

## Interface
Parameters:
- `T`, no default: payload type carried in the mailbox and on `data_out`.
- `DEPTH`, 0: mailbox bound in items; 0 means unbounded.
- `CLEAR_ON_RESET`, 1: mailbox is emptied while reset is asserted.
- `MIN_GAP`, 0: minimum idle cycles inserted after each accepted transfer.
- `MAX_GAP`, 0: maximum idle cycles; must be >= `MIN_GAP`; equal values give a fixed gap.
- `SEED`, 32'h1: initial LFSR state; must be non-zero.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst`, in, 1: reset, asynchronous and active-low.
- `valid_out`, out, 1: `data_out` holds an item.
- `data_out`, out, $bits(T): current item.
- `ready_in`, in, 1: consumer accepts the item. A transfer is `valid_out && ready_in` at a rising edge.
- `busy`, out, 1: an item is presented, or a gap is counting down.
- `sent_count`, out, 32: number of transfers accepted since reset. Wraps modulo 2^32.

Tasks and functions:
- `put(input T)`: blocks while `num() == DEPTH` (DEPTH > 0).
- `try_put(input T)`: returns bit; 0 if full, and the mailbox is unchanged.
- `num()`: returns the mailbox occupancy. The presented item is not counted.
- `clear()`: empties the mailbox; does not touch the presented item.
- `wait_idle()`: returns at the first rising edge where the mailbox is empty and `busy` is 0.

## Operation
- FSM states:
  - IDLE: `valid_out` = 0, no gap pending.
  - PRESENT: `valid_out` = 1.
  - GAP: `valid_out` = 0, gap counter > 0.
- IDLE transitions, at each rising edge:
  - Mailbox non-empty: pop one item into `data_out`, go to PRESENT.
  - Otherwise stay in IDLE.
- PRESENT without a transfer: hold. `data_out` and `valid_out` are stable while `valid_out && !ready_in`.
- PRESENT with a transfer, at the edge:
  - `sent_count` increments.
  - Draw gap g = `MIN_GAP` + (lfsr % (`MAX_GAP` − `MIN_GAP` + 1)); the LFSR advances one step per transfer only.
  - g = 0 and mailbox non-empty: pop the next item at the same edge and stay in PRESENT (back-to-back, one item per cycle).
  - g = 0 and mailbox empty: go to IDLE.
  - g > 0: load the counter with g and go to GAP.
- GAP: decrement each edge. When the counter reaches 0, take the IDLE actions on the next edge, so a gap of g gives exactly g cycles with `valid_out` low.
- `data_out` keeps its last value when `valid_out` = 0. It is X-free after reset.
- A put and a pop in the same timestep are both honoured. Occupancy is checked before the pop.
- `clear()` during PRESENT leaves the presented item in place; it still completes.

## Timing
- Reset values, asynchronous on `rst` falling:
  - Outputs: `valid_out` = 0, `data_out` = '0, `busy` = 0, `sent_count` = 0.
  - Internal: FSM in IDLE, gap counter 0, LFSR = `SEED`.
- Reset mid-operation: the presented item is dropped and is not counted. If `CLEAR_ON_RESET` = 1, the mailbox is emptied on every edge while `rst` is low. Puts during reset are discarded in that case.
- First presentation after reset release: the first rising edge with `rst` high and the mailbox non-empty.
- Latency: an item put before edge N (block idle) is visible on `valid_out`/`data_out` right after edge N.
- Peak throughput is one transfer per cycle with `MAX_GAP` = 0 and `ready_in` = 1.
- Gap cycles are counted only after an accepted transfer. Back-pressure cycles do not consume gap.

## Structure
- Shared package `kanagawa_sim_pkg` holds:
  - the 32-bit LFSR taps constant (x^32+x^22+x^2+x+1);
  - function `lfsr_next`;
  - function `draw_gap(lfsr, min, max)`.
- Sub-module: interface `KanagawaSimMailboxWriter #(T)`, the write-side mirror of the existing reader interface. It owns the bounded queue and provides `put`, `try_put`, `internal_try_get`, `num` and `clear`.
- The top module holds the FSM, gap counter, LFSR, output registers and `sent_count`.

## Test plan
- Fixed gap, no back-pressure: put 4 items 0xA..0xD, `ready_in` = 1, `MIN_GAP` = `MAX_GAP` = 0. Required: `valid_out` high for 4 consecutive cycles with data A, B, C, D; then low; `sent_count` = 4.
- Back-pressure: put 0x11, hold `ready_in` = 0 for 5 cycles. Required: `valid_out` = 1 and `data_out` = 0x11 stable for all 5; transfer on the 6th edge; `sent_count` = 1.
- Fixed gap of 3: `MIN_GAP` = `MAX_GAP` = 3, put 3 items, `ready_in` = 1. Required: valid pattern 1,0,0,0,1,0,0,0,1.
- Bounded mailbox: `DEPTH` = 2, three `try_put` calls with no clock. Required: return 1, 1, 0; `num()` = 2.
- Reset mid-operation: assert `rst` low between edges while 0x55 is presented with 2 more queued. Required: `valid_out` falls immediately, without waiting for an edge; after release, `num()` = 0 and `sent_count` = 0.
- Random gaps, `MIN_GAP` = 1, `MAX_GAP` = 4, 100 items. Required:
  - every gap is within 1..4;
  - all 100 items arrive in order;
  - `wait_idle()` returns after the last transfer.

Source files
------------

// File: rtl/kanagawa_sim_pkg.sv
// Shared helpers for the simulation source/sink stages: FSM states, 32-bit LFSR
// (x^32+x^22+x^2+x+1, Galois form) and the idle-gap draw.
package kanagawa_sim_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } mb_state_e;

  function automatic logic [31:0] lfsr_next(input logic [31:0] lfsr);
    return {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [31:0] draw_gap(input logic [31:0] lfsr,
                                           input logic [31:0] min_gap,
                                           input logic [31:0] max_gap);
    return min_gap + (lfsr % (max_gap - min_gap + 32'd1));
  endfunction

endpackage

// File: rtl/kanagawa_sim_mailbox_to_ready_valid_writer.sv
// Write side of the simulation mailbox: an append-only store plus a read index
// owned by the consumer, so producer tasks and the consumer never write the same variable.
interface KanagawaSimMailboxWriter #(
  parameter type T              = logic [31:0],
  parameter int  DEPTH          = 0,
  parameter bit  CLEAR_ON_RESET = 1'b1
) (
  input logic clk,
  input logic rst,
  input int   rd_idx
);

  T     store[$];
  int   wr_cnt;
  int   clr_base;
  int   head_idx;
  logic avail;

  // clear() only moves a floor under the consumer's read index
  assign head_idx = (rd_idx > clr_base) ? rd_idx : clr_base;
  assign avail    = (wr_cnt > head_idx);

  function automatic int num();
    return wr_cnt - head_idx;
  endfunction

  function automatic bit try_put(input T item);
    if (CLEAR_ON_RESET && !rst) return 1'b0;
    if ((DEPTH > 0) && (num() >= DEPTH)) return 1'b0;
    store.push_back(item);
    wr_cnt = wr_cnt + 1;
    return 1'b1;
  endfunction

  task automatic put(input T item);
    while (!(CLEAR_ON_RESET && !rst) && (DEPTH > 0) && (num() >= DEPTH))
      @(negedge clk);
    void'(try_put(item));
  endtask

  function automatic void clear();
    clr_base = wr_cnt;
  endfunction

  // Head item; the consumer commits the pop by advancing rd_idx.
  function automatic T internal_try_get();
    T item;
    item = '0;
    if (avail) item = store[head_idx];
    return item;
  endfunction

endinterface

// File: rtl/kanagawa_sim_mailbox_to_ready_valid.sv
// Mailbox-fed ready/valid source; an item queued before edge N is presented right after N.
// Holds data while ready_in is low; inserts a random MIN_GAP..MAX_GAP idle gap after each transfer.
module kanagawa_sim_mailbox_to_ready_valid
  import kanagawa_sim_pkg::*;
#(
  parameter type         T              = logic [31:0],
  parameter int          DEPTH          = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter int unsigned MIN_GAP        = 0,
  parameter int unsigned MAX_GAP        = 0,
  parameter logic [31:0] SEED           = 32'h1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        valid_out,
  output T            data_out,
  input  logic        ready_in,
  output logic        busy,
  output logic [31:0] sent_count
);

  mb_state_e   state_q, state_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] cnt_d;
  logic [31:0] gap_draw;
  logic        pop;
  int          rd_idx;

  KanagawaSimMailboxWriter #(
    .T             (T),
    .DEPTH         (DEPTH),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) mbox (
    .clk   (clk),
    .rst   (rst),
    .rd_idx(rd_idx)
  );

  always_comb begin
    gap_draw = draw_gap(lfsr_q, MIN_GAP, MAX_GAP);
    state_d  = state_q;
    gap_d    = gap_q;
    lfsr_d   = lfsr_q;
    cnt_d    = sent_count;
    pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mbox.avail) begin
          pop     = 1'b1;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (ready_in) begin
          cnt_d  = sent_count + 32'd1;
          lfsr_d = lfsr_next(lfsr_q);
          if (gap_draw != 32'd0) begin
            gap_d   = gap_draw;
            state_d = ST_GAP;
          end else if (mbox.avail) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // The edge that retires the last gap cycle also performs the idle pop
        if (gap_q > 32'd1) begin
          gap_d = gap_q - 32'd1;
        end else begin
          gap_d = '0;
          if (mbox.avail) begin
            pop     = 1'b1;
            state_d = ST_PRESENT;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      lfsr_q     <= SEED;
      sent_count <= '0;
      data_out   <= '0;
      rd_idx     <= CLEAR_ON_RESET ? mbox.wr_cnt : mbox.head_idx;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      lfsr_q     <= lfsr_d;
      sent_count <= cnt_d;
      if (pop) begin
        data_out <= mbox.internal_try_get();
        rd_idx   <= mbox.head_idx + 1;
      end
    end
  end

  assign valid_out = (state_q == ST_PRESENT);
  assign busy      = (state_q != ST_IDLE);

  task automatic wait_idle();
    @(posedge clk);
    while ((mbox.num() != 0) || busy) @(posedge clk);
  endtask

endmodule

// File: tb/tb_kanagawa_sim_mailbox_to_ready_valid.sv
// Bench for the mailbox-to-ready/valid source: three instances cover zero gap,
// fixed gap with a bounded mailbox, and random gaps against a queue-based model.
module tb_kanagawa_sim_mailbox_to_ready_valid;

  typedef logic [15:0] item_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        valid_a, ready_a, busy_a;
  item_t       data_a;
  logic [31:0] cnt_a;
  logic        valid_b, ready_b, busy_b;
  item_t       data_b;
  logic [31:0] cnt_b;
  logic        valid_c, ready_c, busy_c;
  item_t       data_c;
  logic [31:0] cnt_c;

  int checks   = 0;
  int failures = 0;
  bit idle_done;

  kanagawa_sim_mailbox_to_ready_valid #(
    .T(item_t), .DEPTH(0), .CLEAR_ON_RESET(1'b1), .MIN_GAP(0), .MAX_GAP(0), .SEED(32'h1)
  ) dut_a (
    .clk(clk), .rst(rst), .valid_out(valid_a), .data_out(data_a),
    .ready_in(ready_a), .busy(busy_a), .sent_count(cnt_a)
  );

  kanagawa_sim_mailbox_to_ready_valid #(
    .T(item_t), .DEPTH(2), .CLEAR_ON_RESET(1'b1), .MIN_GAP(3), .MAX_GAP(3), .SEED(32'hACE1)
  ) dut_b (
    .clk(clk), .rst(rst), .valid_out(valid_b), .data_out(data_b),
    .ready_in(ready_b), .busy(busy_b), .sent_count(cnt_b)
  );

  kanagawa_sim_mailbox_to_ready_valid #(
    .T(item_t), .DEPTH(8), .CLEAR_ON_RESET(1'b1), .MIN_GAP(1), .MAX_GAP(4), .SEED(32'h1234_5678)
  ) dut_c (
    .clk(clk), .rst(rst), .valid_out(valid_c), .data_out(data_c),
    .ready_in(ready_c), .busy(busy_c), .sent_count(cnt_c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    r1, r2, r3;
    bit    pat [9];
    item_t pd  [9];
    item_t src [100];
    int    tries, got, low_run, cyc;
    bit    in_gap, rdy;

    rst     = 1'b0;
    ready_a = 1'b0;
    ready_b = 1'b0;
    ready_c = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_valid_a", 64'(valid_a), 64'd0);
    check("rst_busy_a",  64'(busy_a),  64'd0);
    check("rst_cnt_a",   64'(cnt_a),   64'd0);
    check("rst_data_a",  64'(data_a),  64'd0);
    check("rst_num_a",   64'(dut_a.mbox.num()), 64'd0);
    check("rst_valid_c", 64'(valid_c), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Zero gap, no back-pressure: four back-to-back transfers
    ready_a = 1'b1;
    for (int i = 0; i < 4; i++) dut_a.mbox.put(item_t'(16'hA + i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_valid", 64'(valid_a), 64'd1);
      check("b2b_data",  64'(data_a),  64'(16'hA + i));
    end
    @(negedge clk);
    check("b2b_valid_low", 64'(valid_a), 64'd0);
    check("b2b_count",     64'(cnt_a),   64'd4);

    // Back-pressure: item held stable for five cycles, accepted on the sixth edge
    ready_a = 1'b0;
    dut_a.mbox.put(item_t'(16'h11));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(valid_a), 64'd1);
      check("bp_data",  64'(data_a),  64'h11);
    end
    ready_a = 1'b1;
    @(negedge clk);
    check("bp_valid_low", 64'(valid_a), 64'd0);
    check("bp_count",     64'(cnt_a),   64'd5);

    // Bounded mailbox: third try_put in the same timestep is refused
    r1 = dut_b.mbox.try_put(item_t'(16'h1));
    r2 = dut_b.mbox.try_put(item_t'(16'h2));
    r3 = dut_b.mbox.try_put(item_t'(16'h3));
    check("bound_try1", 64'(r1), 64'd1);
    check("bound_try2", 64'(r2), 64'd1);
    check("bound_try3", 64'(r3), 64'd0);
    check("bound_num",  64'(dut_b.mbox.num()), 64'd2);

    // Fixed gap of three idle cycles between transfers
    ready_b = 1'b1;
    pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pd  = '{16'h1, 16'h0, 16'h0, 16'h0, 16'h2, 16'h0, 16'h0, 16'h0, 16'h3};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("gap3_valid", 64'(valid_b), 64'(pat[i]));
      if (pat[i]) check("gap3_data", 64'(data_b), 64'(pd[i]));
      if (i == 0) begin
        r3 = dut_b.mbox.try_put(item_t'(16'h3));
        check("gap3_refill", 64'(r3), 64'd1);
      end
    end
    repeat (4) @(negedge clk);
    check("gap3_busy",  64'(busy_b), 64'd0);
    check("gap3_count", 64'(cnt_b),  64'd3);
    check("gap3_num",   64'(dut_b.mbox.num()), 64'd0);

    // Reset mid-operation: presented item dropped, queue flushed, puts discarded
    ready_a = 1'b0;
    dut_a.mbox.put(item_t'(16'h55));
    dut_a.mbox.put(item_t'(16'h66));
    dut_a.mbox.put(item_t'(16'h77));
    @(negedge clk);
    check("rstmid_valid_pre", 64'(valid_a), 64'd1);
    check("rstmid_data_pre",  64'(data_a),  64'h55);
    check("rstmid_num_pre",   64'(dut_a.mbox.num()), 64'd2);
    #2 rst = 1'b0;
    #1;
    check("rstmid_valid_async", 64'(valid_a), 64'd0);
    check("rstmid_busy_async",  64'(busy_a),  64'd0);
    check("rstmid_cnt_async",   64'(cnt_a),   64'd0);
    @(negedge clk);
    dut_a.mbox.put(item_t'(16'h99));
    check("rstmid_num_during", 64'(dut_a.mbox.num()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_num_after",   64'(dut_a.mbox.num()), 64'd0);
    check("rstmid_valid_after", 64'(valid_a), 64'd0);
    check("rstmid_cnt_after",   64'(cnt_a),   64'd0);
    check("rstmid_data_after",  64'(data_a),  64'd0);

    // Random gaps 1..4 with random back-pressure; model is the ordered source list
    for (int i = 0; i < 100; i++) src[i] = item_t'($urandom);
    got     = 0;
    low_run = 0;
    in_gap  = 1'b0;
    cyc     = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          tries = 0;
          while (!dut_c.mbox.try_put(src[i]) && (tries < 4000)) begin
            @(negedge clk);
            tries++;
          end
        end
      end
      begin
        while ((got < 100) && (cyc < 4000)) begin
          @(negedge clk);
          cyc++;
          rdy = ($urandom_range(0, 3) != 0);
          if (valid_c) begin
            if (in_gap) begin
              check("rand_gap_range", 64'((low_run >= 1) && (low_run <= 4)), 64'd1);
              in_gap = 1'b0;
            end
            if (rdy) begin
              check("rand_data", 64'(data_c), 64'(src[got]));
              got++;
              in_gap  = 1'b1;
              low_run = 0;
            end
          end else if (in_gap) begin
            low_run++;
          end
          ready_c = rdy;
        end
      end
    join
    check("rand_all_arrived", 64'(got), 64'd100);

    idle_done = 1'b0;
    fork
      begin
        dut_c.wait_idle();
        idle_done = 1'b1;
      end
    join_none
    cyc = 0;
    while (!idle_done && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
    end
    check("rand_wait_idle", 64'(idle_done), 64'd1);
    @(negedge clk);
    check("rand_count",      64'(cnt_c),   64'd100);
    check("rand_busy_end",   64'(busy_c),  64'd0);
    check("rand_valid_end",  64'(valid_c), 64'd0);
    check("rand_num_end",    64'(dut_c.mbox.num()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
